// File: rtl/screen_clear_sweeper.sv
// ---------------------------------------------------------------------------
// screen_clear_sweeper
//
// Raster-sweep pixel generator. After a start it writes one colour to every
// pixel of the screen, or of a rectangle, in row-major order with x varying
// fastest. Pixels are offered to the framebuffer pixel port and advance only
// when the framebuffer accepts them.
//
// Optional feature macro: CLEAR_RECT_EN
//   undefined : the whole WIDTH x HEIGHT screen is swept; no rect ports.
//   defined   : adds rect_x0/rect_y0/rect_x1/rect_y1, latched on an accepted
//               start. x1/y1 are clamped to the screen edge. An empty rect
//               goes straight to DONE without writing any pixel.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        request a sweep; sampled only in IDLE
//   abort        stop the current sweep (SWEEP only); no done pulse
//   color_in     fill colour, latched on an accepted start
//   pixel_ready  framebuffer accepts the current pixel this cycle
//   x, y         current pixel coordinate
//   pixel_color  latched fill colour
//   pixel_write  pixel valid; high in SWEEP only
//   busy         high in SWEEP and DONE
//   done         one-cycle pulse after the last pixel is accepted
//   state_dbg    current FSM state (IDLE=0, SWEEP=1, DONE=2)
//   rect_*       rectangle corners (CLEAR_RECT_EN only)
//
// Handshake: pixel_write is the valid. A pixel transfers on a rising clk edge
// where pixel_write && pixel_ready. While pixel_write=1 and pixel_ready=0 the
// offered x, y and pixel_color are held stable. pixel_write never depends
// combinationally on pixel_ready.
// ---------------------------------------------------------------------------
module screen_clear_sweeper #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          color_in,
    input  logic          pixel_ready,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pixel_color,
    output logic          pixel_write,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
`ifdef CLEAR_RECT_EN
    ,
    input  logic [CW-1:0] rect_x0,
    input  logic [CW-1:0] rect_y0,
    input  logic [CW-1:0] rect_x1,
    input  logic [CW-1:0] rect_y1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(HEIGHT - 1);

    state_t state;

    // Bounds as seen at the moment a start is accepted (start_*), and the
    // bounds that govern the running sweep (cur_*).
    logic [CW-1:0] start_x0;
    logic [CW-1:0] start_y0;
    logic          start_empty;
    logic [CW-1:0] cur_x0;
    logic [CW-1:0] cur_x1;
    logic [CW-1:0] cur_y1;

`ifdef CLEAR_RECT_EN
    logic [CW-1:0] x1_clamp;
    logic [CW-1:0] y1_clamp;
    logic [CW-1:0] x0_q;
    logic [CW-1:0] x1_q;
    logic [CW-1:0] y1_q;

    // Far corner is clipped to the screen; the near corner is not, so a
    // near corner beyond the clipped far corner means an empty rect.
    assign x1_clamp    = (rect_x1 > X_LAST) ? X_LAST : rect_x1;
    assign y1_clamp    = (rect_y1 > Y_LAST) ? Y_LAST : rect_y1;
    assign start_x0    = rect_x0;
    assign start_y0    = rect_y0;
    assign start_empty = (rect_x0 > x1_clamp) || (rect_y0 > y1_clamp);

    // Rect inputs are free to change mid-sweep; only the copy taken at
    // start matters. y0 is not needed after start (rows only increase).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else if (state == IDLE && start) begin
            x0_q <= rect_x0;
            x1_q <= x1_clamp;
            y1_q <= y1_clamp;
        end
    end

    assign cur_x0 = x0_q;
    assign cur_x1 = x1_q;
    assign cur_y1 = y1_q;
`else
    assign start_x0    = '0;
    assign start_y0    = '0;
    assign start_empty = 1'b0;
    assign cur_x0      = '0;
    assign cur_x1      = X_LAST;
    assign cur_y1      = Y_LAST;
`endif

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pixel_color <= color_in;
                        x           <= start_x0;
                        y           <= start_y0;
                        busy        <= 1'b1;
                        if (start_empty) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            pixel_write <= 1'b0;
                        end else begin
                            state       <= SWEEP;
                            pixel_write <= 1'b1;
                        end
                    end
                end

                SWEEP: begin
                    // abort wins over a same-cycle accept.
                    if (abort) begin
                        state       <= IDLE;
                        pixel_write <= 1'b0;
                        busy        <= 1'b0;
                    end else if (pixel_ready) begin
                        if (x == cur_x1) begin
                            if (y == cur_y1) begin
                                state       <= DONE;
                                pixel_write <= 1'b0;
                                done        <= 1'b1;
                            end else begin
                                x <= cur_x0;
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end

                DONE: begin
                    // start seen here is dropped, not queued.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    pixel_write <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
